cam_capture: RTL and testbench
==============================

CAM_CAPTURE -- requirements
Module: cam_capture

Interface
REQ-001 Parameter CAM_WIDTH, default 640: active pixels per line.
REQ-002 Parameter CAM_HEIGHT, default 480: active lines per frame.
REQ-003 Parameter SKIP_FRAMES, default 2: complete frames discarded after reset or re-enable (sensor settling).
REQ-004 Parameter VSYNC_POL, default 1: 1 = vsync_in high during sync; 0 = low during sync.
REQ-005 PCLK  in  1  sensor pixel clock; all logic on the rising edge; single clock domain.
REQ-006 n_rst  in  1  reset, asynchronous, active-low.
REQ-007 vsync_in  in  1  sensor frame sync, polarity per VSYNC_POL.
REQ-008 href  in  1  sensor line valid, active-high.
REQ-009 d  in  8  sensor data byte, RGB565 high byte first.
REQ-010 capture_en  in  1  level enable for frame capture.
REQ-011 pixel_out  out  16  assembled pixel {first byte, second byte}.
REQ-012 pixel_valid  out  1  one-cycle strobe qualifying pixel_out.
REQ-013 frame_active  out  1  high only while the current frame is captured; low means between frames or idle.
REQ-014 frame_done  out  1  one-cycle pulse at the end of each captured frame.
REQ-015 frame_cnt  out  16  count of captured frames, wraps 0xFFFF->0.
REQ-016 err_flags  out  3  sticky per frame: [0] odd byte count in a line, [1] line length != CAM_WIDTH, [2] line count != CAM_HEIGHT.

Function
REQ-017 vsync_in, href, d SHALL be registered once on PCLK before any use; all timing below refers to the registered copies.
REQ-018 FSM states: IDLE, SKIP, ARMED, CAPTURE.
REQ-019 IDLE -> SKIP on the first sync assertion while capture_en=1; skip counter loads SKIP_FRAMES.
REQ-020 SKIP: each sync assertion decrements the skip counter; on reaching 0 -> ARMED. SKIP_FRAMES=0 goes straight from IDLE to ARMED.
REQ-021 ARMED -> CAPTURE on sync deassertion; CAPTURE -> ARMED on sync assertion, which also pulses frame_done and increments frame_cnt.
REQ-022 When capture_en=0 in ARMED -> IDLE. In CAPTURE, the current frame completes, then -> IDLE.
REQ-023 frame_active SHALL be 1 exactly while the state is CAPTURE.
REQ-024 Byte phase resets to 0 whenever href=0. In CAPTURE with href=1: phase 0 stores the byte as the high byte; phase 1 drives pixel_out={high, byte} and pulses pixel_valid.
REQ-025 Latency: pixel_valid is high in the cycle following the second PCLK edge after the pin-level low byte is sampled.
REQ-026 h_cnt counts emitted pixels in a line; pixels with h_cnt >= CAM_WIDTH SHALL be suppressed (no pixel_valid).
REQ-027 v_cnt increments on each href falling edge in CAPTURE; lines with v_cnt >= CAM_HEIGHT SHALL be suppressed.
REQ-028 href falling with phase=1 sets err_flags[0]; href falling with an h_cnt other than CAM_WIDTH sets err_flags[1].
REQ-029 Sync assertion in CAPTURE with v_cnt != CAM_HEIGHT sets err_flags[2].
REQ-030 err_flags, h_cnt and v_cnt SHALL clear on ARMED->CAPTURE.
REQ-031 No pixel_valid outside CAPTURE, including href activity during SKIP or ARMED.
REQ-032 Counter widths: h_cnt $clog2(CAM_WIDTH+1), v_cnt $clog2(CAM_HEIGHT+1); counters saturate rather than wrap.

Reset
REQ-033 When n_rst=0: state IDLE; pixel_out 0; pixel_valid, frame_active, frame_done 0; frame_cnt 0; err_flags 0; phase, counters and input registers 0.
REQ-034 Reset mid-frame SHALL abandon the frame; after release, capture restarts from IDLE, including the full SKIP_FRAMES.

Structure
REQ-035 Package cam_pkg SHALL hold the FSM state enum, default CAM_WIDTH/CAM_HEIGHT and err_flags bit indices.
REQ-036 Single module, no sub-module; pixel_valid/pixel_out/frame_active drive the frame buffer's pixel_valid/pixel_in/VSYNC inputs directly.

Verification
REQ-037 Reset, capture_en=1, SKIP_FRAMES=2, three 640x480 frames -> no pixel_valid in frames 1-2; frame 3 yields 307200 strobes, one frame_done, frame_cnt=1, err_flags=0.
REQ-038 Bytes 0xAB, 0xCD at line start -> pixel_out=0xABCD with one-cycle pixel_valid at the REQ-025 latency.
REQ-039 Line of 1281 bytes -> 640 pixels emitted; err_flags[0]=1 and err_flags[1]=0 until the next frame start.
REQ-040 Frame of 482 lines -> lines 481-482 suppressed; err_flags[2]=1 at frame_done.
REQ-041 capture_en dropped at line 100 -> frame completes with 307200 strobes, frame_done pulses, state IDLE; the next frame yields no strobes.
REQ-042 n_rst pulsed mid-line -> all outputs 0 immediately; after release, SKIP_FRAMES frames are skipped before strobes resume.

Source files
------------

// File: rtl/cam_pkg.sv
// Shared types and constants for the camera capture front end.
package cam_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SKIP    = 2'd1,
        ST_ARMED   = 2'd2,
        ST_CAPTURE = 2'd3
    } cam_state_e;

    localparam int CAM_WIDTH_DEF  = 640;
    localparam int CAM_HEIGHT_DEF = 480;

    // err_flags bit positions
    localparam int ERR_ODD_BYTES = 0;
    localparam int ERR_LINE_LEN  = 1;
    localparam int ERR_FRAME_LEN = 2;

endpackage

// File: rtl/cam_capture_if.sv
// Sensor byte bus in, assembled pixel stream out.
interface cam_capture_if;
    logic        vsync_in;
    logic        href;
    logic [7:0]  d;
    logic [15:0] pixel_out;
    logic        pixel_valid;

    // master: the sensor/consumer side; slave: the capture block
    modport master (output vsync_in, href, d, input pixel_out, pixel_valid);
    modport slave  (input vsync_in, href, d, output pixel_out, pixel_valid);
endinterface

// File: rtl/cam_capture.sv
// DVP-style camera capture: registers sensor pins, skips settling frames,
// assembles RGB565 byte pairs into pixels and tracks line/frame geometry.
//
// state      | meaning
// -----------+----------------------------------------------------------
// ST_IDLE    | capture disabled or waiting for the first frame sync
// ST_SKIP    | discarding settling frames, skip_q syncs still to go
// ST_ARMED   | sync seen, waiting for it to end to start a frame
// ST_CAPTURE | frame in progress, pixels are emitted
module cam_capture #(
    parameter int CAM_WIDTH   = cam_pkg::CAM_WIDTH_DEF,
    parameter int CAM_HEIGHT  = cam_pkg::CAM_HEIGHT_DEF,
    parameter int SKIP_FRAMES = 2,
    parameter int VSYNC_POL   = 1
) (
    input  logic        PCLK,
    input  logic        n_rst,
    input  logic        capture_en,
    cam_capture_if.slave cam,
    output logic        frame_active,
    output logic        frame_done,
    output logic [15:0] frame_cnt,
    output logic [2:0]  err_flags
);
    import cam_pkg::*;

    localparam int HW = $clog2(CAM_WIDTH + 1);
    localparam int VW = $clog2(CAM_HEIGHT + 1);
    localparam int SW = (SKIP_FRAMES > 0) ? $clog2(SKIP_FRAMES + 1) : 1;
    localparam logic [HW-1:0] H_LEN     = HW'(CAM_WIDTH);
    localparam logic [VW-1:0] V_LEN     = VW'(CAM_HEIGHT);
    localparam logic [SW-1:0] SKIP_INIT = SW'(SKIP_FRAMES);
    localparam logic          VS_ACTIVE = (VSYNC_POL != 0);

    logic          vs_q, vs_prev_q, href_q, href_prev_q;
    logic [7:0]    d_q;
    cam_state_e    state_q, state_d;
    logic [SW-1:0] skip_q, skip_d;
    logic          phase_q;
    logic [7:0]    high_q;
    logic [HW-1:0] h_cnt_q;
    logic [VW-1:0] v_cnt_q;
    logic [15:0]   pixel_out_q, frame_cnt_q;
    logic          pixel_valid_q, frame_done_q;
    logic [2:0]    err_q, err_set;
    logic          sync_rise, sync_fall, line_end, pix_take, pix_emit;
    logic          frame_start, frame_end;

    // Raw vsync is kept so both reset values agree and no false edge appears
    // for either polarity.
    assign sync_rise = (vs_q == VS_ACTIVE) && (vs_prev_q != VS_ACTIVE);
    assign sync_fall = (vs_q != VS_ACTIVE) && (vs_prev_q == VS_ACTIVE);
    assign line_end  = (state_q == ST_CAPTURE) && href_prev_q && !href_q;
    assign pix_take  = (state_q == ST_CAPTURE) && href_q && phase_q;
    assign pix_emit  = pix_take && (h_cnt_q < H_LEN) && (v_cnt_q < V_LEN);

    // Single capture stage on the sensor pins, plus one delayed copy for edges.
    always_ff @(posedge PCLK or negedge n_rst) begin
        if (!n_rst) begin
            vs_q        <= 1'b0;
            vs_prev_q   <= 1'b0;
            href_q      <= 1'b0;
            href_prev_q <= 1'b0;
            d_q         <= '0;
        end else begin
            vs_q        <= cam.vsync_in;
            vs_prev_q   <= vs_q;
            href_q      <= cam.href;
            href_prev_q <= href_q;
            d_q         <= cam.d;
        end
    end

    // Frame sequencing: settling skip, arm on sync, capture between syncs.
    always_comb begin
        state_d     = state_q;
        skip_d      = skip_q;
        frame_start = 1'b0;
        frame_end   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (capture_en && sync_rise) begin
                    if (SKIP_FRAMES == 0) begin
                        state_d = ST_ARMED;
                    end else begin
                        state_d = ST_SKIP;
                        skip_d  = SKIP_INIT;
                    end
                end
            end
            ST_SKIP: begin
                if (!capture_en) begin
                    state_d = ST_IDLE;
                end else if (sync_rise) begin
                    skip_d = skip_q - SW'(1);
                    if (skip_q <= SW'(1)) state_d = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (!capture_en) begin
                    state_d = ST_IDLE;
                end else if (sync_fall) begin
                    state_d     = ST_CAPTURE;
                    frame_start = 1'b1;
                end
            end
            ST_CAPTURE: begin
                // a disable only takes effect once the running frame ends
                if (sync_rise) begin
                    frame_end = 1'b1;
                    state_d   = capture_en ? ST_ARMED : ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Geometry errors detected this cycle.
    always_comb begin
        err_set                = '0;
        err_set[ERR_ODD_BYTES] = line_end && phase_q;
        err_set[ERR_LINE_LEN]  = line_end && (h_cnt_q != H_LEN);
        err_set[ERR_FRAME_LEN] = frame_end && (v_cnt_q != V_LEN);
    end

    // FSM state register.
    always_ff @(posedge PCLK or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= ST_IDLE;
            skip_q  <= '0;
        end else begin
            state_q <= state_d;
            skip_q  <= skip_d;
        end
    end

    // Byte pairing, line/frame counters, sticky errors and output strobes.
    always_ff @(posedge PCLK or negedge n_rst) begin
        if (!n_rst) begin
            phase_q       <= 1'b0;
            high_q        <= '0;
            h_cnt_q       <= '0;
            v_cnt_q       <= '0;
            pixel_out_q   <= '0;
            pixel_valid_q <= 1'b0;
            frame_done_q  <= 1'b0;
            frame_cnt_q   <= '0;
            err_q         <= '0;
        end else begin
            phase_q       <= href_q ? ~phase_q : 1'b0;
            if (href_q && !phase_q) high_q <= d_q;
            pixel_valid_q <= pix_emit;
            if (pix_emit) pixel_out_q <= {high_q, d_q};
            frame_done_q  <= frame_end;
            if (frame_end) frame_cnt_q <= frame_cnt_q + 16'd1;
            if (frame_start) begin
                h_cnt_q <= '0;
                v_cnt_q <= '0;
                err_q   <= '0;
            end else begin
                if (line_end)                      h_cnt_q <= '0;
                else if (pix_take && h_cnt_q != '1) h_cnt_q <= h_cnt_q + HW'(1);
                if (line_end && v_cnt_q != '1)     v_cnt_q <= v_cnt_q + VW'(1);
                err_q <= err_q | err_set;
            end
        end
    end

    assign cam.pixel_out   = pixel_out_q;
    assign cam.pixel_valid = pixel_valid_q;
    assign frame_active    = (state_q == ST_CAPTURE);
    assign frame_done      = frame_done_q;
    assign frame_cnt       = frame_cnt_q;
    assign err_flags       = err_q;

endmodule

// File: tb/tb_cam_capture.sv
// Scoreboard bench for cam_capture using a reduced 4x4 frame geometry.
module tb_cam_capture;

    localparam int W    = 4;
    localparam int H    = 4;
    localparam int SKIP = 2;

    typedef struct {
        logic [15:0] pix;
        int          cyc;
    } exp_t;

    logic        pclk;
    logic        n_rst;
    logic        capture_en;
    logic        frame_active;
    logic        frame_done;
    logic [15:0] frame_cnt;
    logic [2:0]  err_flags;

    cam_capture_if bus();

    cam_capture #(
        .CAM_WIDTH(W), .CAM_HEIGHT(H), .SKIP_FRAMES(SKIP), .VSYNC_POL(1)
    ) dut (
        .PCLK(pclk),
        .n_rst(n_rst),
        .capture_en(capture_en),
        .cam(bus),
        .frame_active(frame_active),
        .frame_done(frame_done),
        .frame_cnt(frame_cnt),
        .err_flags(err_flags)
    );

    int         checks = 0;
    int         passed = 0;
    int         cyc = 0;
    int         done_cnt = 0;
    logic [2:0] err_at_done = '0;
    exp_t       sb[$];

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    always @(posedge pclk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Monitor: every strobe must match the oldest expected pixel, value and cycle.
    always @(negedge pclk) begin
        exp_t e;
        if (bus.pixel_valid === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                $display("FAIL unexpected_pixel: got %h expected none (t=%0t)", bus.pixel_out, $time);
            end else begin
                e = sb.pop_front();
                check("pixel_value", 32'(bus.pixel_out), 32'(e.pix));
                check("pixel_cycle", cyc, e.cyc);
            end
        end
        if (frame_done === 1'b1) begin
            done_cnt++;
            err_at_done = err_flags;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    task automatic vsync_rise();
        @(negedge pclk) bus.vsync_in = 1'b1;
        repeat (3) @(negedge pclk);
    endtask

    task automatic vsync_fall();
        @(negedge pclk) bus.vsync_in = 1'b0;
        repeat (3) @(negedge pclk);
    endtask

    // Low byte driven at this negedge: sampled at the next edge, strobe after the one after.
    task automatic send_line(input int nbytes, input logic [7:0] seed, input bit cap, input int lineno);
        logic [7:0] hi;
        logic [7:0] b;
        exp_t       e;
        hi = '0;
        for (int i = 0; i < nbytes; i++) begin
            b = seed + 8'(i * 34);
            @(negedge pclk);
            bus.href = 1'b1;
            bus.d    = b;
            if (i % 2 == 0) begin
                hi = b;
            end else if (cap && (i / 2) < W && lineno < H) begin
                e.pix = {hi, b};
                e.cyc = cyc + 2;
                sb.push_back(e);
            end
        end
        @(negedge pclk);
        bus.href = 1'b0;
        bus.d    = '0;
        repeat (3) @(negedge pclk);
    endtask

    task automatic send_lines(input int nlines, input int bad_line, input int bad_bytes,
                              input logic [7:0] seed0, input bit cap, input int drop_line);
        for (int l = 0; l < nlines; l++) begin
            int nb;
            nb = (l == bad_line) ? bad_bytes : 2 * W;
            if (l == drop_line) capture_en = 1'b0;
            send_line(nb, seed0 + 8'(l * 7), cap, l);
            if (l == 0) check("frame_active", 32'(frame_active), 32'(cap));
        end
    endtask

    task automatic send_frame(input logic [7:0] seed0, input bit cap);
        vsync_rise();
        vsync_fall();
        send_lines(H, -1, 0, seed0, cap, -1);
    endtask

    initial begin
        n_rst        = 1'b0;
        capture_en   = 1'b0;
        bus.vsync_in = 1'b0;
        bus.href     = 1'b0;
        bus.d        = '0;
        repeat (3) @(negedge pclk);
        check("rst_pixel_out", 32'(bus.pixel_out), 32'h0);
        check("rst_pixel_valid", 32'(bus.pixel_valid), 32'h0);
        check("rst_frame_active", 32'(frame_active), 32'h0);
        check("rst_frame_done", 32'(frame_done), 32'h0);
        check("rst_frame_cnt", 32'(frame_cnt), 32'h0);
        check("rst_err_flags", 32'(err_flags), 32'h0);
        n_rst      = 1'b1;
        capture_en = 1'b1;

        // two settling frames, then a clean captured frame
        send_frame(8'h10, 1'b0);
        send_frame(8'h20, 1'b0);
        send_frame(8'h30, 1'b1);
        vsync_rise();
        check("f3_done_cnt", done_cnt, 1);
        check("f3_frame_cnt", 32'(frame_cnt), 32'd1);
        check("f3_err", 32'(err_at_done), 32'h0);
        check("f3_drained", sb.size(), 0);
        vsync_fall();

        // line starting 0xAB, 0xCD -> 0xABCD
        send_lines(H, -1, 0, 8'hAB, 1'b1, -1);
        vsync_rise();
        check("f4_frame_cnt", 32'(frame_cnt), 32'd2);
        check("f4_err", 32'(err_at_done), 32'h0);
        check("f4_drained", sb.size(), 0);
        vsync_fall();

        // odd byte count line: 2W+1 bytes
        send_lines(H, 1, 2 * W + 1, 8'h50, 1'b1, -1);
        vsync_rise();
        check("f5_err_done", 32'(err_at_done), 32'b001);
        check("f5_frame_cnt", 32'(frame_cnt), 32'd3);
        repeat (5) @(negedge pclk);
        check("f5_err_held", 32'(err_flags), 32'b001);
        vsync_fall();
        check("f6_err_cleared", 32'(err_flags), 32'b000);

        // two extra lines, suppressed
        send_lines(H + 2, -1, 0, 8'h60, 1'b1, -1);
        vsync_rise();
        check("f6_err_done", 32'(err_at_done), 32'b100);
        check("f6_frame_cnt", 32'(frame_cnt), 32'd4);
        check("f6_drained", sb.size(), 0);
        vsync_fall();

        // short line, even byte count
        send_lines(H, 2, 2 * W - 2, 8'h70, 1'b1, -1);
        vsync_rise();
        check("f7_err_done", 32'(err_at_done), 32'b010);
        vsync_fall();

        // disable mid-frame: frame still completes, then idle
        send_lines(H, -1, 0, 8'h80, 1'b1, 1);
        vsync_rise();
        check("f8_done_cnt", done_cnt, 6);
        check("f8_frame_cnt", 32'(frame_cnt), 32'd6);
        check("f8_err", 32'(err_at_done), 32'h0);
        check("f8_drained", sb.size(), 0);
        vsync_fall();
        check("f8_idle", 32'(frame_active), 32'h0);
        send_lines(H, -1, 0, 8'h90, 1'b0, -1);
        vsync_rise();
        check("f9_frame_cnt", 32'(frame_cnt), 32'd6);
        vsync_fall();

        // re-enable, skip two, reset in the middle of a captured line
        capture_en = 1'b1;
        send_frame(8'hA0, 1'b0);
        send_frame(8'hB0, 1'b0);
        vsync_rise();
        vsync_fall();
        send_line(2 * W, 8'hC0, 1'b1, 0);
        check("f12_active", 32'(frame_active), 32'h1);
        @(negedge pclk);
        bus.href = 1'b1;
        bus.d    = 8'h55;
        @(negedge pclk);
        #1 n_rst = 1'b0;
        #1;
        check("mid_rst_pixel_out", 32'(bus.pixel_out), 32'h0);
        check("mid_rst_pixel_valid", 32'(bus.pixel_valid), 32'h0);
        check("mid_rst_frame_active", 32'(frame_active), 32'h0);
        check("mid_rst_frame_done", 32'(frame_done), 32'h0);
        check("mid_rst_frame_cnt", 32'(frame_cnt), 32'h0);
        check("mid_rst_err", 32'(err_flags), 32'h0);
        check("mid_rst_drained", sb.size(), 0);
        bus.href = 1'b0;
        bus.d    = '0;
        @(negedge pclk);
        n_rst = 1'b1;

        send_frame(8'hD0, 1'b0);
        send_frame(8'hD8, 1'b0);
        send_frame(8'hE0, 1'b1);
        vsync_rise();
        check("f15_frame_cnt", 32'(frame_cnt), 32'd1);
        check("f15_done_cnt", done_cnt, 7);
        check("f15_err", 32'(err_at_done), 32'h0);
        check("f15_drained", sb.size(), 0);
        vsync_fall();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
